// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_if
//  Description : Instruction-memory fetch bus. The fetch stage (master)
//                raises imem_req with a word-aligned imem_addr and holds both
//                steady until the memory (slave) answers with imem_ready and
//                imem_rdata. imem_ready may arrive in the cycle req rises.
//  Signals     : imem_req   - fetch request              (master -> slave)
//                imem_addr  - 32-bit word address        (master -> slave)
//                imem_rdata - fetched instruction word   (slave  -> master)
//                imem_ready - completes the request      (slave  -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : IF stage plus IF/ID pipeline register. Holds the PC, fetches
//                words from a variable-latency instruction memory, selects the
//                next PC from the target returned by ID, and presents pc4/inst
//                to ID. Fetches completing under stall are parked in a
//                one-entry buffer; a redirect while a request is outstanding
//                waits out (and discards) that response in DROP.
//  Ports       : clk       - clock, rising edge
//                clr       - synchronous active-high reset
//                stall_en  - freeze PC and IF/ID register
//                pcsource  - 00 seq, 01 bpc, 10 ra, 11 jpc
//                bpc/jpc/ra- redirect targets
//                imem      - fetch bus (master side)
//                pc4/inst  - IF/ID register contents
//                if_valid  - IF/ID slot holds a real instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  wire logic           clk,
   input  wire logic           clr,
   input  wire logic           stall_en,
   input  wire logic [1:0]     pcsource,
   input  wire logic [31:0]    bpc,
   input  wire logic [31:0]    jpc,
   input  wire logic [31:0]    ra,
   instruction_fetch_if.master imem,
   output logic [31:0]         pc4,
   output logic [31:0]         inst,
   output logic                if_valid
);

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DROP  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] inst_q, inst_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] drop_addr_q, drop_addr_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        done;

   assign pc_plus4 = pc_q + 32'd4;

   // A stalled redirect is ignored: ID re-presents it once the stall clears.
   assign redirect = (pcsource != 2'b00) && !stall_en;

   always_comb begin
      target = pc_q;
      case (pcsource)
         2'b01:   target = bpc;
         2'b10:   target = ra;
         2'b11:   target = jpc;
         default: target = pc_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pc4_d       = pc4_q;
      inst_d      = inst_q;
      if_valid_d  = if_valid_q;
      buf_inst_d  = buf_inst_q;
      buf_pc4_d   = buf_pc4_q;
      buf_valid_d = buf_valid_q;
      drop_addr_d = drop_addr_q;
      fetch_req   = 1'b0;
      fetch_addr  = {pc_q[31:2], 2'b00};

      case (state_q)
         FETCH: begin
            // No new request while a parked word waits to be drained.
            fetch_req  = !buf_valid_q;
            fetch_addr = {pc_q[31:2], 2'b00};
         end
         DROP: begin
            // Keep the abandoned request on the bus until memory completes it.
            fetch_req  = 1'b1;
            fetch_addr = drop_addr_q;
         end
         default: begin
            fetch_req  = 1'b0;
         end
      endcase

      // Reset cycle never requests; pending state is replaced on this edge.
      if (clr) begin
         fetch_req = 1'b0;
      end

      done = fetch_req && imem.imem_ready;

      if (redirect) begin
         pc_d        = target;
         inst_d      = NOP_INST;
         if_valid_d  = 1'b0;
         buf_valid_d = 1'b0;
         if (state_q == FETCH) begin
            if (fetch_req && !imem.imem_ready) begin
               state_d     = DROP;
               drop_addr_d = fetch_addr;
            end
         end else if (done) begin
            state_d = FETCH;
         end
      end else if (stall_en) begin
         if (done) begin
            if (state_q == FETCH) begin
               buf_inst_d  = imem.imem_rdata;
               buf_pc4_d   = pc_plus4;
               buf_valid_d = 1'b1;
               pc_d        = pc_plus4;
            end else begin
               state_d = FETCH;
            end
         end
      end else if (state_q == DROP) begin
         inst_d     = NOP_INST;
         if_valid_d = 1'b0;
         if (done) begin
            state_d = FETCH;
         end
      end else if (buf_valid_q) begin
         inst_d      = buf_inst_q;
         pc4_d       = buf_pc4_q;
         if_valid_d  = 1'b1;
         buf_valid_d = 1'b0;
      end else if (done) begin
         inst_d     = imem.imem_rdata;
         pc4_d      = pc_plus4;
         if_valid_d = 1'b1;
         pc_d       = pc_plus4;
      end else begin
         // ID consumed the previous slot and memory has nothing yet.
         inst_d     = NOP_INST;
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         pc4_q       <= 32'd0;
         inst_q      <= NOP_INST;
         if_valid_q  <= 1'b0;
         buf_inst_q  <= 32'd0;
         buf_pc4_q   <= 32'd0;
         buf_valid_q <= 1'b0;
         drop_addr_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pc4_q       <= pc4_d;
         inst_q      <= inst_d;
         if_valid_q  <= if_valid_d;
         buf_inst_q  <= buf_inst_d;
         buf_pc4_q   <= buf_pc4_d;
         buf_valid_q <= buf_valid_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   assign imem.imem_req  = fetch_req;
   assign imem.imem_addr = fetch_addr;
   assign pc4            = pc4_q;
   assign inst           = inst_q;
   assign if_valid       = if_valid_q;

endmodule
`default_nettype wire
